// File: rtl/gbe_rxof_pkg.sv
// Shared types and constants for the 10GbE RX overflow event counter.
// The optional GBE_RXOF_SAT_EN build macro is consumed by gbe_rxof_ctr_cell.
package gbe_rxof_pkg;

    localparam int CTR_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_OVF     = 2'd1,
        ST_RECOVER = 2'd2
    } rxof_state_t;

    function automatic logic is_active(input rxof_state_t st);
        return (st != ST_NORMAL) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/gbe_rxof_ctr_cell.sv
// Single event counter with enable and synchronous clear.
// Saturates at all-ones when GBE_RXOF_SAT_EN is defined, otherwise wraps modulo 2^W.
module gbe_rxof_ctr_cell #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ZERO     = {W{1'b0}};
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    // Counter register: clear has priority over an increment in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= ZERO;
        end else if (clr) begin
            count <= ZERO;
        end else if (en && inc) begin
`ifdef GBE_RXOF_SAT_EN
            if (count != ALL_ONES) begin
                count <= count + ONE;
            end else begin
                count <= count;
            end
`else
            count <= count + ONE;
`endif
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/gbe_rxof_counter.sv
// RX buffer overflow tracker: counts overflow events and frames dropped while recovering.
// Build macro GBE_RXOF_SAT_EN selects saturating (defined) or wrapping (undefined) counters.
module gbe_rxof_counter
    import gbe_rxof_pkg::*;
#(
    parameter int CTR_W = CTR_W_DEFAULT
) (
    input  logic             user_clk,
    input  logic             user_rst,
    input  logic             rx_overflow,
    input  logic             rx_valid,
    input  logic             rx_eof,
    input  logic             ctr_en,
    input  logic             ctr_clr,
    output logic [CTR_W-1:0] ofctr_out,
    output logic [CTR_W-1:0] dropctr_out,
    output logic             of_active
);

    rxof_state_t state_r;
    rxof_state_t state_next_s;
    logic        ovf_prev_r;
    logic        ovf_armed_r;
    logic        ovf_rise_s;
    logic        frame_end_s;
    logic        drop_inc_s;

    // Edge detection is only armed once rx_overflow has been seen low since reset,
    // so an overflow already in progress at reset release is never counted.
    always_comb begin
        ovf_rise_s  = rx_overflow & ~ovf_prev_r & ovf_armed_r;
        frame_end_s = rx_valid & rx_eof;
        drop_inc_s  = frame_end_s & is_active(state_r);
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_NORMAL: begin
                if (ovf_rise_s) begin
                    state_next_s = ST_OVF;
                end else begin
                    state_next_s = ST_NORMAL;
                end
            end
            ST_OVF: begin
                if (!rx_overflow) begin
                    state_next_s = ST_RECOVER;
                end else begin
                    state_next_s = ST_OVF;
                end
            end
            ST_RECOVER: begin
                if (ovf_rise_s) begin
                    state_next_s = ST_OVF;
                end else if (frame_end_s && !rx_overflow) begin
                    state_next_s = ST_NORMAL;
                end else begin
                    state_next_s = ST_RECOVER;
                end
            end
            default: begin
                state_next_s = ST_NORMAL;
            end
        endcase
    end

    // State, edge-detect history and the registered activity flag.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_r     <= ST_NORMAL;
            ovf_prev_r  <= 1'b0;
            ovf_armed_r <= 1'b0;
            of_active   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            ovf_prev_r  <= rx_overflow;
            ovf_armed_r <= ovf_armed_r | ~rx_overflow;
            of_active   <= is_active(state_next_s);
        end
    end

    gbe_rxof_ctr_cell #(
        .W (CTR_W)
    ) u_ofctr (
        .clk   (user_clk),
        .rst   (user_rst),
        .en    (ctr_en),
        .clr   (ctr_clr),
        .inc   (ovf_rise_s),
        .count (ofctr_out)
    );

    gbe_rxof_ctr_cell #(
        .W (CTR_W)
    ) u_dropctr (
        .clk   (user_clk),
        .rst   (user_rst),
        .en    (ctr_en),
        .clr   (ctr_clr),
        .inc   (drop_inc_s),
        .count (dropctr_out)
    );

endmodule

// File: tb/tb_gbe_rxof_counter.sv
// Self-checking bench for gbe_rxof_counter: directed scenarios plus random traffic
// checked every cycle against an event-level reference model (32-bit and 4-bit instances).
module tb_gbe_rxof_counter;

    logic        user_clk = 1'b0;
    logic        user_rst = 1'b0;
    logic        rx_overflow = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_eof = 1'b0;
    logic        ctr_en = 1'b1;
    logic        ctr_clr = 1'b0;
    logic [31:0] ofctr_out, dropctr_out;
    logic        of_active;
    logic [3:0]  ofctr4, dropctr4;
    logic        of_active4;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0 normal, 1 overflow, 2 recovering; raw counts since clear.
    int     m_phase;
    bit     m_prev, m_seen_low;
    longint of_raw, drop_raw;

    always #5 user_clk = ~user_clk;

    gbe_rxof_counter dut (
        .user_clk(user_clk), .user_rst(user_rst), .rx_overflow(rx_overflow),
        .rx_valid(rx_valid), .rx_eof(rx_eof), .ctr_en(ctr_en), .ctr_clr(ctr_clr),
        .ofctr_out(ofctr_out), .dropctr_out(dropctr_out), .of_active(of_active)
    );

    gbe_rxof_counter #(.CTR_W(4)) dut4 (
        .user_clk(user_clk), .user_rst(user_rst), .rx_overflow(rx_overflow),
        .rx_valid(rx_valid), .rx_eof(rx_eof), .ctr_en(ctr_en), .ctr_clr(ctr_clr),
        .ofctr_out(ofctr4), .dropctr_out(dropctr4), .of_active(of_active4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] width_view(input longint raw, input int w);
        longint maxv = (longint'(1) << w) - 1;
`ifdef GBE_RXOF_SAT_EN
        return (raw > maxv) ? maxv : raw;
`else
        return raw & maxv;
`endif
    endfunction

    task automatic model_reset();
        m_phase = 0; m_prev = 0; m_seen_low = 0; of_raw = 0; drop_raw = 0;
    endtask

    task automatic model_cycle();
        bit rise, frame;
        rise  = rx_overflow && !m_prev && m_seen_low;
        frame = rx_valid && rx_eof;
        if (ctr_clr) begin
            of_raw = 0; drop_raw = 0;
        end else begin
            if (ctr_en && rise) of_raw++;
            if (ctr_en && frame && m_phase != 0) drop_raw++;
        end
        if (m_phase == 0 && rise) m_phase = 1;
        else if (m_phase == 1 && !rx_overflow) m_phase = 2;
        else if (m_phase == 2 && rise) m_phase = 1;
        else if (m_phase == 2 && frame && !rx_overflow) m_phase = 0;
        m_prev = rx_overflow;
        if (!rx_overflow) m_seen_low = 1;
    endtask

    task automatic compare_all();
        check("ofctr32",   ofctr_out,   width_view(of_raw, 32));
        check("dropctr32", dropctr_out, width_view(drop_raw, 32));
        check("active32",  of_active,   m_phase != 0);
        check("ofctr4",    ofctr4,      width_view(of_raw, 4));
        check("dropctr4",  dropctr4,    width_view(drop_raw, 4));
        check("active4",   of_active4,  m_phase != 0);
    endtask

    task automatic step();
        @(posedge user_clk);
        if (user_rst) model_reset();
        else model_cycle();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input int hi, input int lo);
        rx_overflow = 1'b1;
        step();
        check("active_after_rise", of_active, 1'b1);
        for (int i = 1; i < hi; i++) step();
        rx_overflow = 1'b0;
        idle(lo);
    endtask

    task automatic frame();
        rx_valid = 1'b1; rx_eof = 1'b1;
        step();
        rx_valid = 1'b0; rx_eof = 1'b0;
    endtask

    task automatic clear();
        ctr_clr = 1'b1;
        step();
        ctr_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        user_rst = 1'b1;
        #1;
        check("reset_of", ofctr_out, 32'd0);
        check("reset_act", of_active, 1'b0);
        idle(2);
        #3 user_rst = 1'b0;
        idle(3);

        // Three separate overflow pulses.
        for (int i = 0; i < 3; i++) pulse(2, 10);
        check("three_pulses", ofctr_out, 32'd3);
        frame();
        check("back_normal", of_active, 1'b0);
        check("one_drop", dropctr_out, 32'd1);

        // Long overflow, then four frames: only the first is a drop.
        clear();
        pulse(100, 3);
        for (int i = 0; i < 4; i++) begin
            frame();
            idle(2);
        end
        check("long_of", ofctr_out, 32'd1);
        check("long_drop", dropctr_out, 32'd1);
        check("long_active", of_active, 1'b0);

        // eof without valid is ignored.
        pulse(2, 2);
        rx_eof = 1'b1;
        idle(3);
        rx_eof = 1'b0;
        check("eof_novalid_active", of_active, 1'b1);
        check("eof_novalid_drop", dropctr_out, 32'd1);
        frame();

        // Clear colliding with a rising edge.
        clear();
        for (int i = 0; i < 5; i++) pulse(2, 3);
        check("five_events", ofctr_out, 32'd5);
        ctr_clr = 1'b1; rx_overflow = 1'b1;
        step();
        ctr_clr = 1'b0;
        check("clr_wins", ofctr_out, 32'd0);
        check("clr_active", of_active, 1'b1);
        idle(3);
        check("held_no_recount", ofctr_out, 32'd0);
        rx_overflow = 1'b0;
        idle(2);
        frame();

        // Counting disabled for two events, enabled for one.
        clear();
        ctr_en = 1'b0;
        pulse(2, 4);
        pulse(2, 4);
        ctr_en = 1'b1;
        pulse(2, 4);
        check("en_gate", ofctr_out, 32'd1);
        frame();

        // Seventeen events on both widths.
        clear();
        for (int i = 0; i < 17; i++) pulse(1, 2);
        check("seventeen32", ofctr_out, 32'd17);
`ifdef GBE_RXOF_SAT_EN
        check("seventeen4", ofctr4, 4'hF);
`else
        check("seventeen4", ofctr4, 4'h1);
`endif
        frame();

        // Reset mid-overflow with rx_overflow held high.
        rx_overflow = 1'b1;
        idle(3);
        check("pre_rst_active", of_active, 1'b1);
        user_rst = 1'b1;
        #1;
        model_reset();
        check("rst_async_of", ofctr_out, 32'd0);
        check("rst_async_act", of_active, 1'b0);
        idle(2);
        #3 user_rst = 1'b0;
        idle(5);
        check("rst_held_of", ofctr_out, 32'd0);
        check("rst_held_act", of_active, 1'b0);
        rx_overflow = 1'b0;
        idle(2);
        pulse(2, 2);
        check("rst_new_edge", ofctr_out, 32'd1);
        frame();

        // Random traffic checked against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) rx_overflow = ~rx_overflow;
            rx_valid = ($urandom_range(0, 1) == 1);
            rx_eof   = ($urandom_range(0, 2) == 0);
            ctr_en   = ($urandom_range(0, 7) != 0);
            ctr_clr  = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gbe_rxof_counter.md
GBE_RXOF_COUNTER -- requirements
Module: gbe_rxof_counter

Interface
REQ-001 Parameter CTR_W, default 32: width of both event counters and of ofctr_out/dropctr_out.
REQ-002 user_clk  input  1  sole clock; all logic rises on its positive edge.
REQ-003 user_rst  input  1  asynchronous, active-high reset.
REQ-004 rx_overflow  input  1  10GbE core RX buffer overflow flag, level, user_clk domain.
REQ-005 rx_valid  input  1  RX data word valid strobe from the core.
REQ-006 rx_eof  input  1  end-of-frame marker; meaningful only when rx_valid=1.
REQ-007 ctr_en  input  1  count enable; level.
REQ-008 ctr_clr  input  1  single-cycle synchronous clear request.
REQ-009 ofctr_out  output  CTR_W  overflow event count; drives the software-readable rxofctr register user_data_in.
REQ-010 dropctr_out  output  CTR_W  count of frames discarded during overflow recovery.
REQ-011 of_active  output  1  high while FSM is not in NORMAL.

Function
REQ-012 FSM states: NORMAL, OVF, RECOVER; encoding 2 bits, state register updated every cycle.
REQ-013 NORMAL -> OVF when rx_overflow=1 and registered previous rx_overflow=0 (rising edge).
REQ-014 OVF -> RECOVER when rx_overflow=0.
REQ-015 RECOVER -> NORMAL on a cycle with rx_valid=1 and rx_eof=1 and rx_overflow=0.
REQ-016 RECOVER -> OVF on a new rx_overflow rising edge; this edge is counted as a new event.
REQ-017 Overflow event count increments by 1 on every rising edge of rx_overflow (NORMAL or RECOVER) when ctr_en=1.
REQ-018 Drop count increments by 1 on every rx_valid&rx_eof cycle while state is OVF or RECOVER and ctr_en=1, including the frame end that causes RECOVER -> NORMAL.
REQ-019 ctr_en=0 freezes both counters; FSM and edge detector continue to track inputs.
REQ-020 ctr_clr=1 zeroes both counters on the next edge; clear wins over a simultaneous increment; FSM state unaffected.
REQ-021 ofctr_out, dropctr_out, of_active are registered: an increment-causing input at edge N is visible on outputs after edge N+1 (latency 1 cycle from sampled input).
REQ-022 rx_overflow held high continuously counts exactly one event.
REQ-023 rx_eof with rx_valid=0 is ignored.

Reset
REQ-024 user_rst=1 asynchronously forces state NORMAL, edge-detect register 0, ofctr_out=0, dropctr_out=0, of_active=0.
REQ-025 Reset asserted mid-overflow discards in-progress state; after release with rx_overflow already high, no event is counted until rx_overflow falls and rises again.

Configuration
REQ-026 Macro GBE_RXOF_SAT_EN defined: both counters saturate at all-ones (2^CTR_W-1) and hold until clear or reset.
REQ-027 Macro GBE_RXOF_SAT_EN undefined: both counters wrap from all-ones to 0 modulo 2^CTR_W.

Structure
REQ-028 Package gbe_rxof_pkg holds the FSM state enum type and the CTR_W default constant.
REQ-029 Sub-module gbe_rxof_ctr_cell (enable, clear, increment, saturate-or-wrap per macro) is instantiated twice, once per counter.

Verification
REQ-030 Reset, then 3 separate rx_overflow pulses (2 cycles high, 10 low) with ctr_en=1 -> ofctr_out=3, of_active high 1 cycle after each rising edge.
REQ-031 rx_overflow high 100 cycles, then low, then 4 frames (rx_valid&rx_eof) -> ofctr_out=1, dropctr_out=1, FSM NORMAL after first frame end, of_active=0.
REQ-032 ctr_clr and an overflow rising edge in the same cycle with ofctr_out=5 -> ofctr_out=0 next cycle, of_active=1.
REQ-033 CTR_W=4, 17 events: with GBE_RXOF_SAT_EN -> ofctr_out=4'hF; without -> ofctr_out=4'h1.
REQ-034 ctr_en=0 during 2 events, then ctr_en=1 for 1 event -> ofctr_out=1, FSM transitions still occur.
REQ-035 user_rst pulsed while in OVF with rx_overflow held high -> outputs 0, state NORMAL, ofctr_out remains 0 until next rising edge.
